// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receive and transmit engines.
//   rx_state_t     : receive FSM state encoding
//   FRAME_W/DATA_W : frame and payload widths
//   *_IDX          : field positions inside the raw 11-bit frame
//   frame_to_byte  : extracts the LSB-first payload from a raw frame
package uart_pkg;

  localparam int FRAME_W   = 11;
  localparam int DATA_W    = 8;
  localparam int START_IDX = 10;
  localparam int PAR_IDX   = 1;
  localparam int STOP_IDX  = 0;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DATA       = 3'd1,
    PARITY     = 3'd2,
    STOP       = 3'd3,
    BREAK_WAIT = 3'd4
  } rx_state_t;

  // The frame is stored in arrival order, so d0 sits just below the start
  // bit and the byte has to be bit-reversed out of it.
  function automatic logic [DATA_W-1:0] frame_to_byte(input logic [FRAME_W-1:0] frame);
    logic [DATA_W-1:0] b;
    b = '0;
    for (int i = 0; i < DATA_W; i++) begin
      b[i] = frame[START_IDX-1-i];
    end
    return b;
  endfunction

endpackage

// File: rtl/uart_rx_hold.sv
// uart_rx_hold
// One-deep holding register for received frames with a valid/ready handshake
// and a sticky overrun flag.
//   i_clk, i_rst    : clock, synchronous active-high reset
//   i_commit        : a complete frame is presented this cycle
//   i_data/i_frame  : byte and raw frame of the committed frame
//   i_perr/i_ferr   : error flags of the committed frame
//   i_ready         : consumer accepts the held frame
//   o_data/o_frame  : held byte and raw frame
//   o_valid         : holding register full
//   o_perr/o_ferr   : error flags of the held frame
//   o_overrun       : a frame was dropped because the register was full
module uart_rx_hold
  import uart_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_commit,
  input  logic [DATA_W-1:0]  i_data,
  input  logic [FRAME_W-1:0] i_frame,
  input  logic               i_perr,
  input  logic               i_ferr,
  input  logic               i_ready,
  output logic [DATA_W-1:0]  o_data,
  output logic [FRAME_W-1:0] o_frame,
  output logic               o_valid,
  output logic               o_perr,
  output logic               o_ferr,
  output logic               o_overrun
);

  logic [DATA_W-1:0]  r_data;
  logic [FRAME_W-1:0] r_frame;
  logic               r_valid;
  logic               r_perr;
  logic               r_ferr;
  logic               r_overrun;

  logic w_accept;
  logic w_load;

  assign w_accept = r_valid & i_ready;
  // An accept in the same cycle frees the slot, so the new frame still lands.
  assign w_load   = i_commit & (~r_valid | i_ready);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data    <= '0;
      r_frame   <= '0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_load) begin
        r_data  <= i_data;
        r_frame <= i_frame;
        r_perr  <= i_perr;
        r_ferr  <= i_ferr;
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end

      // Commit with the register full and no accept implies a dropped frame.
      if (w_accept) begin
        r_overrun <= 1'b0;
      end else if (i_commit & r_valid) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign o_data    = r_data;
  assign o_frame   = r_frame;
  assign o_valid   = r_valid;
  assign o_perr    = r_perr;
  assign o_ferr    = r_ferr;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx
// Receive-side UART frame engine: start 0, 8 data bits LSB first, parity,
// stop, one bit per clock. Checks parity and stop, then hands the frame to
// a one-deep holding register.
//   UART_CLK, UART_RST : clock, synchronous active-high reset
//   RX_Serial          : synchronous serial line
//   RX_READY           : consumer accepts the held frame
//   RX_DATA, Packet_In : held byte and raw frame (start at [10], stop at [0])
//   RX_VALID           : holding register full
//   PARITY_ERR         : parity mismatch on the held frame
//   FRAME_ERR          : bad stop bit on the held frame
//   OVERRUN            : sticky, a frame was dropped
//   RX_BUSY            : FSM is not in IDLE
//
// state      | meaning
// -----------+-------------------------------------------------------
// IDLE       | waiting for a start bit (line at !IDLE_LEVEL)
// DATA       | shifting in d0..d7, r_bit_cnt selects the bit
// PARITY     | capturing the parity bit
// STOP       | sampling the stop bit, frame committed this cycle
// BREAK_WAIT | bad stop bit seen, waiting for the line to return idle
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter logic PARITY_ODD = 1'b0,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic               UART_CLK,
  input  logic               UART_RST,
  input  logic               RX_Serial,
  input  logic               RX_READY,
  output logic [DATA_W-1:0]  RX_DATA,
  output logic [FRAME_W-1:0] Packet_In,
  output logic               RX_VALID,
  output logic               PARITY_ERR,
  output logic               FRAME_ERR,
  output logic               OVERRUN,
  output logic               RX_BUSY
);

  rx_state_t r_state;
  rx_state_t w_state_nxt;

  logic [2:0]         r_bit_cnt;
  // start, d0..d7, parity in arrival order; the stop bit comes straight
  // from the line in the commit cycle.
  logic [FRAME_W-2:0] r_shift;

  logic               w_start;
  logic               w_commit;
  logic [FRAME_W-1:0] w_frame;
  logic [DATA_W-1:0]  w_byte;
  logic               w_perr;
  logic               w_ferr;

  assign w_start  = (RX_Serial == ~IDLE_LEVEL);
  assign w_commit = (r_state == STOP);
  assign w_frame  = {r_shift, RX_Serial};
  assign w_byte   = frame_to_byte(w_frame);
  assign w_perr   = ((^w_byte) ^ w_frame[PAR_IDX]) != PARITY_ODD;
  assign w_ferr   = (w_frame[STOP_IDX] != IDLE_LEVEL);

  always_ff @(posedge UART_CLK) begin
    if (UART_RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_start) w_state_nxt = DATA;
      end
      DATA: begin
        if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
      end
      PARITY: begin
        w_state_nxt = STOP;
      end
      STOP: begin
        // A low stop bit may be a break; never reinterpret it as a start.
        w_state_nxt = w_ferr ? BREAK_WAIT : IDLE;
      end
      BREAK_WAIT: begin
        if (RX_Serial == IDLE_LEVEL) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge UART_CLK) begin
    if (UART_RST) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_bit_cnt <= '0;
            r_shift   <= {{(FRAME_W-2){1'b0}}, RX_Serial};
          end
        end
        DATA: begin
          r_shift   <= {r_shift[FRAME_W-3:0], RX_Serial};
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        PARITY: begin
          r_shift <= {r_shift[FRAME_W-3:0], RX_Serial};
        end
        default: begin
        end
      endcase
    end
  end

  uart_rx_hold u_hold (
    .i_clk     (UART_CLK),
    .i_rst     (UART_RST),
    .i_commit  (w_commit),
    .i_data    (w_byte),
    .i_frame   (w_frame),
    .i_perr    (w_perr),
    .i_ferr    (w_ferr),
    .i_ready   (RX_READY),
    .o_data    (RX_DATA),
    .o_frame   (Packet_In),
    .o_valid   (RX_VALID),
    .o_perr    (PARITY_ERR),
    .o_ferr    (FRAME_ERR),
    .o_overrun (OVERRUN)
  );

  assign RX_BUSY = (r_state != IDLE);

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx
// Directed bench for uart_frame_rx. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a period away from the
// sampling edge of the design.
module tb_uart_frame_rx;

  logic        UART_CLK = 1'b0;
  logic        UART_RST;
  logic        RX_Serial;
  logic        RX_READY;
  logic [7:0]  RX_DATA;
  logic [10:0] Packet_In;
  logic        RX_VALID;
  logic        PARITY_ERR;
  logic        FRAME_ERR;
  logic        OVERRUN;
  logic        RX_BUSY;

  int errors = 0;
  int checks = 0;

  uart_frame_rx dut (
    .UART_CLK   (UART_CLK),
    .UART_RST   (UART_RST),
    .RX_Serial  (RX_Serial),
    .RX_READY   (RX_READY),
    .RX_DATA    (RX_DATA),
    .Packet_In  (Packet_In),
    .RX_VALID   (RX_VALID),
    .PARITY_ERR (PARITY_ERR),
    .FRAME_ERR  (FRAME_ERR),
    .OVERRUN    (OVERRUN),
    .RX_BUSY    (RX_BUSY)
  );

  always #5 UART_CLK = ~UART_CLK;

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par, input logic stp);
    logic [10:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) f[9-i] = d[i];
    f[1] = par;
    f[0] = stp;
    return f;
  endfunction

  // Drives the first n bits of a frame, one per falling edge, MSB (start) first.
  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge UART_CLK);
      RX_Serial = f[10-i];
    end
  endtask

  task automatic idle_tick();
    @(negedge UART_CLK);
    RX_Serial = 1'b1;
  endtask

  task automatic test_reset();
    UART_RST  = 1'b1;
    RX_Serial = 1'b1;
    RX_READY  = 1'b0;
    repeat (2) @(negedge UART_CLK);
    UART_RST = 1'b0;
    checks++;
    if ({RX_DATA, Packet_In, RX_VALID, PARITY_ERR, FRAME_ERR, OVERRUN, RX_BUSY} !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs got data=%h pkt=%h v=%b pe=%b fe=%b ov=%b busy=%b expected all 0",
               RX_DATA, Packet_In, RX_VALID, PARITY_ERR, FRAME_ERR, OVERRUN, RX_BUSY);
    end
  endtask

  task automatic test_clean_frame();
    RX_READY = 1'b1;
    send_bits(mk_frame(8'hA5, 1'b0, 1'b1), 11);
    idle_tick();
    checks++;
    if (RX_VALID !== 1'b1) begin errors++; $display("FAIL a5_valid got=%b exp=1", RX_VALID); end
    checks++;
    if (RX_DATA !== 8'hA5) begin errors++; $display("FAIL a5_data got=%h exp=a5", RX_DATA); end
    checks++;
    if (Packet_In !== 11'h295) begin errors++; $display("FAIL a5_packet got=%h exp=295", Packet_In); end
    checks++;
    if ({PARITY_ERR, FRAME_ERR} !== 2'b00) begin
      errors++; $display("FAIL a5_errflags got=%b%b exp=00", PARITY_ERR, FRAME_ERR);
    end
    checks++;
    if (RX_BUSY !== 1'b0) begin errors++; $display("FAIL a5_busy got=%b exp=0", RX_BUSY); end
    idle_tick();
    checks++;
    if (RX_VALID !== 1'b0) begin errors++; $display("FAIL a5_valid_pulse got=%b exp=0", RX_VALID); end
  endtask

  task automatic test_parity_err();
    RX_READY = 1'b1;
    send_bits(mk_frame(8'h07, 1'b0, 1'b1), 11);
    idle_tick();
    checks++;
    if (RX_VALID !== 1'b1) begin errors++; $display("FAIL par_valid got=%b exp=1", RX_VALID); end
    checks++;
    if (RX_DATA !== 8'h07) begin errors++; $display("FAIL par_data got=%h exp=07", RX_DATA); end
    checks++;
    if (Packet_In !== 11'h381) begin errors++; $display("FAIL par_packet got=%h exp=381", Packet_In); end
    checks++;
    if (PARITY_ERR !== 1'b1) begin errors++; $display("FAIL par_perr got=%b exp=1", PARITY_ERR); end
    checks++;
    if (FRAME_ERR !== 1'b0) begin errors++; $display("FAIL par_ferr got=%b exp=0", FRAME_ERR); end
    idle_tick();
  endtask

  task automatic test_framing();
    RX_READY = 1'b1;
    send_bits(mk_frame(8'h3C, 1'b0, 1'b0), 11);
    @(negedge UART_CLK);
    RX_Serial = 1'b0;
    checks++;
    if (RX_VALID !== 1'b1) begin errors++; $display("FAIL brk_valid got=%b exp=1", RX_VALID); end
    checks++;
    if (Packet_In !== 11'h0F0) begin errors++; $display("FAIL brk_packet got=%h exp=0f0", Packet_In); end
    checks++;
    if ({PARITY_ERR, FRAME_ERR} !== 2'b01) begin
      errors++; $display("FAIL brk_errflags got=%b%b exp=01", PARITY_ERR, FRAME_ERR);
    end
    checks++;
    if (RX_BUSY !== 1'b1) begin errors++; $display("FAIL brk_busy got=%b exp=1", RX_BUSY); end
    for (int i = 0; i < 5; i++) begin
      @(negedge UART_CLK);
      RX_Serial = (i == 4) ? 1'b1 : 1'b0;
      checks++;
      if ({RX_VALID, RX_BUSY} !== 2'b01) begin
        errors++; $display("FAIL brk_hold%0d got v=%b busy=%b exp v=0 busy=1", i, RX_VALID, RX_BUSY);
      end
    end
    idle_tick();
    checks++;
    if (RX_BUSY !== 1'b0) begin errors++; $display("FAIL brk_release got=%b exp=0", RX_BUSY); end
    send_bits(mk_frame(8'h55, 1'b0, 1'b1), 11);
    idle_tick();
    checks++;
    if (RX_VALID !== 1'b1) begin errors++; $display("FAIL x55_valid got=%b exp=1", RX_VALID); end
    checks++;
    if (RX_DATA !== 8'h55) begin errors++; $display("FAIL x55_data got=%h exp=55", RX_DATA); end
    checks++;
    if (Packet_In !== 11'h2A9) begin errors++; $display("FAIL x55_packet got=%h exp=2a9", Packet_In); end
    checks++;
    if ({PARITY_ERR, FRAME_ERR} !== 2'b00) begin
      errors++; $display("FAIL x55_errflags got=%b%b exp=00", PARITY_ERR, FRAME_ERR);
    end
    idle_tick();
  endtask

  task automatic test_back_to_back();
    RX_READY = 1'b0;
    send_bits(mk_frame(8'h11, 1'b0, 1'b1), 11);
    send_bits(mk_frame(8'h22, 1'b0, 1'b1), 11);
    idle_tick();
    checks++;
    if (RX_VALID !== 1'b1) begin errors++; $display("FAIL b2b_valid got=%b exp=1", RX_VALID); end
    checks++;
    if (RX_DATA !== 8'h11) begin errors++; $display("FAIL b2b_data got=%h exp=11", RX_DATA); end
    checks++;
    if (OVERRUN !== 1'b1) begin errors++; $display("FAIL b2b_overrun got=%b exp=1", OVERRUN); end
    idle_tick();
    checks++;
    if ({OVERRUN, RX_VALID, RX_DATA} !== {1'b1, 1'b1, 8'h11}) begin
      errors++; $display("FAIL b2b_sticky got ov=%b v=%b data=%h exp ov=1 v=1 data=11", OVERRUN, RX_VALID, RX_DATA);
    end
    @(negedge UART_CLK);
    RX_READY = 1'b1;
    @(negedge UART_CLK);
    RX_READY = 1'b0;
    checks++;
    if (RX_VALID !== 1'b0) begin errors++; $display("FAIL b2b_accept_valid got=%b exp=0", RX_VALID); end
    checks++;
    if (OVERRUN !== 1'b0) begin errors++; $display("FAIL b2b_accept_overrun got=%b exp=0", OVERRUN); end
  endtask

  task automatic test_accept_commit();
    RX_READY = 1'b0;
    send_bits(mk_frame(8'h33, 1'b0, 1'b1), 11);
    idle_tick();
    checks++;
    if ({RX_VALID, RX_DATA} !== {1'b1, 8'h33}) begin
      errors++; $display("FAIL ac_hold got v=%b data=%h exp v=1 data=33", RX_VALID, RX_DATA);
    end
    send_bits(mk_frame(8'h5A, 1'b0, 1'b1), 11);
    idle_tick();
    checks++;
    if ({OVERRUN, RX_DATA} !== {1'b1, 8'h33}) begin
      errors++; $display("FAIL ac_drop got ov=%b data=%h exp ov=1 data=33", OVERRUN, RX_DATA);
    end
    send_bits(mk_frame(8'h44, 1'b0, 1'b1), 10);
    @(negedge UART_CLK);
    RX_Serial = 1'b1;
    RX_READY  = 1'b1;
    @(negedge UART_CLK);
    RX_READY  = 1'b0;
    RX_Serial = 1'b1;
    checks++;
    if (RX_VALID !== 1'b1) begin errors++; $display("FAIL ac_valid got=%b exp=1", RX_VALID); end
    checks++;
    if (RX_DATA !== 8'h44) begin errors++; $display("FAIL ac_data got=%h exp=44", RX_DATA); end
    checks++;
    if (Packet_In !== 11'h089) begin errors++; $display("FAIL ac_packet got=%h exp=089", Packet_In); end
    checks++;
    if (OVERRUN !== 1'b0) begin errors++; $display("FAIL ac_overrun got=%b exp=0", OVERRUN); end
    idle_tick();
    checks++;
    if (RX_VALID !== 1'b1) begin errors++; $display("FAIL ac_valid_held got=%b exp=1", RX_VALID); end
  endtask

  task automatic test_reset_midframe();
    RX_READY = 1'b0;
    send_bits(mk_frame(8'h99, 1'b0, 1'b1), 11);
    idle_tick();
    checks++;
    if ({OVERRUN, RX_DATA} !== {1'b1, 8'h44}) begin
      errors++; $display("FAIL rst_pre got ov=%b data=%h exp ov=1 data=44", OVERRUN, RX_DATA);
    end
    send_bits(mk_frame(8'hFF, 1'b0, 1'b1), 5);
    checks++;
    if (RX_BUSY !== 1'b1) begin errors++; $display("FAIL rst_busy got=%b exp=1", RX_BUSY); end
    @(negedge UART_CLK);
    RX_Serial = 1'b1;
    UART_RST  = 1'b1;
    @(negedge UART_CLK);
    UART_RST  = 1'b0;
    RX_Serial = 1'b1;
    checks++;
    if ({RX_DATA, Packet_In, RX_VALID, PARITY_ERR, FRAME_ERR, OVERRUN, RX_BUSY} !== 24'h0) begin
      errors++;
      $display("FAIL rst_mid got data=%h pkt=%h v=%b pe=%b fe=%b ov=%b busy=%b expected all 0",
               RX_DATA, Packet_In, RX_VALID, PARITY_ERR, FRAME_ERR, OVERRUN, RX_BUSY);
    end
    RX_READY = 1'b1;
    send_bits(mk_frame(8'h81, 1'b0, 1'b1), 11);
    idle_tick();
    checks++;
    if (RX_VALID !== 1'b1) begin errors++; $display("FAIL x81_valid got=%b exp=1", RX_VALID); end
    checks++;
    if (RX_DATA !== 8'h81) begin errors++; $display("FAIL x81_data got=%h exp=81", RX_DATA); end
    checks++;
    if (Packet_In !== 11'h205) begin errors++; $display("FAIL x81_packet got=%h exp=205", Packet_In); end
    checks++;
    if ({PARITY_ERR, FRAME_ERR} !== 2'b00) begin
      errors++; $display("FAIL x81_errflags got=%b%b exp=00", PARITY_ERR, FRAME_ERR);
    end
    idle_tick();
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_parity_err();
    test_framing();
    test_back_to_back();
    test_accept_commit();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Receive-side UART frame engine for the UART_1/UART_2 link. It deserialises the 11-bit frame the transmitters emit: start 0, 8 data bits LSB first, even parity, stop 1, at one bit per clock. It checks parity and stop bit, then presents the byte and the raw frame through a one-deep holding register with a valid/ready handshake. It sits between the inter-UART serial wire (RX_Serial) and the consuming logic. It replaces the ad-hoc counter-based receive path with a standalone block.

## Interface
- PARITY_ODD, default 0: 0 means even parity (the link default); 1 means odd.
- IDLE_LEVEL, default 1: line level while idle (stop-bit level).

- UART_CLK  in  1  sole clock; all logic on posedge.
- UART_RST  in  1  reset, synchronous and active-high.
- RX_Serial  in  1  serial line, one bit per UART_CLK, already synchronous.
- RX_READY  in  1  consumer accepts the held frame this cycle.
- RX_DATA  out  8  received byte.
- Packet_In  out  11  raw frame: [10]=start, [9:2]=d0..d7, [1]=parity, [0]=stop.
- RX_VALID  out  1  holding register full.
- PARITY_ERR  out  1  parity mismatch on the held frame; qualified by RX_VALID.
- FRAME_ERR  out  1  stop bit sampled 0 on the held frame; qualified by RX_VALID.
- OVERRUN  out  1  sticky: a frame completed while the holding register was full and not being accepted.
- RX_BUSY  out  1  FSM is not in IDLE.

## Operation
- FSM states:
  - IDLE: RX_Serial == !IDLE_LEVEL → DATA, bit_cnt=0, start bit stored.
  - DATA: shift in one bit per cycle into d[bit_cnt]; after bit_cnt==7 → PARITY.
  - PARITY: store the parity bit → STOP.
  - STOP: sample the stop bit and commit the frame. Stop == IDLE_LEVEL → IDLE. Otherwise → BREAK_WAIT.
  - BREAK_WAIT: stay until RX_Serial == IDLE_LEVEL, then → IDLE. A low line is never taken as a new start.
- Parity check: err = (^d ^ p) != PARITY_ODD. For even parity, the 9-bit count of ones must be even.
- Commit at the STOP edge:
  - If RX_VALID==0, or RX_READY==1 in the same cycle: load RX_DATA, Packet_In, PARITY_ERR and FRAME_ERR, and set RX_VALID=1.
  - Otherwise: drop the new frame, keep the held frame, and set OVERRUN=1.
- Handshake: RX_VALID && RX_READY with no simultaneous commit clears RX_VALID next edge. Accept plus commit in the same cycle keeps RX_VALID=1 with the new frame.
- OVERRUN clears only on UART_RST or on an accepted handshake.
- Frames with errors are still delivered. Errors are flagged, never suppressed.

## Timing
- Start bit sampled at edge k; d0..d7 at k+1..k+8; parity at k+9; stop at k+10.
- RX_VALID and data are visible after edge k+10. Latency is 11 clocks from the start-bit sample.
- Back-to-back frames: a start bit at edge k+11 is accepted (zero idle gap), except after a framing error.
- Reset values: RX_DATA=0, Packet_In=0, RX_VALID=0, PARITY_ERR=0, FRAME_ERR=0, OVERRUN=0, RX_BUSY=0, FSM=IDLE, bit_cnt=0.
- UART_RST mid-frame aborts the frame: no commit, all outputs go to reset values on that edge. The next start is honoured from the following edge.
- RX_READY while RX_VALID=0 is ignored.

## Structure
- Shared package uart_pkg holds:
  - state encoding (IDLE, DATA, PARITY, STOP, BREAK_WAIT);
  - FRAME_W=11, DATA_W=8;
  - frame field index constants (START_IDX=10, PAR_IDX=1, STOP_IDX=0).
- The same package is reused by the transmit side.
- One sub-module, uart_rx_hold: the holding register plus the valid/ready/overrun logic. The FSM and shifter stay in uart_frame_rx.

## Test plan
- Send 0xA5, frame 0,1,0,1,0,0,1,0,1,0,1 with RX_READY=1 → after 11 clocks RX_DATA=0xA5, Packet_In=0x295, RX_VALID pulses 1 cycle, both error flags are 0.
- Send 0x07 with parity bit 0 (correct value is 1) → RX_DATA=0x07, PARITY_ERR=1, FRAME_ERR=0.
- Send 0x3C with stop bit 0, line held low 5 more clocks, then high, then 0x55 → first frame FRAME_ERR=1; no spurious frame while the line is low; 0x55 received clean.
- Hold RX_READY=0 and send 0x11 then 0x22 back-to-back → RX_DATA stays 0x11 and OVERRUN=1. Then RX_READY=1 for one cycle → RX_VALID=0 and OVERRUN=0.
- Assert UART_RST at edge k+5 of a 0xFF frame → all outputs 0 and FSM IDLE. A following 0x81 is received correctly with parity 0.
- Accept coinciding with commit: RX_READY=1 on the edge that 0x44 completes while 0x33 is held → RX_VALID stays 1, RX_DATA=0x44, OVERRUN=0.
